fp_mul_norm_round: RTL and testbench

- Two-stage pipelined normalize-and-round stage of the FP32 multiplier.
- Sits directly upstream of the multiplier output/special-case stage.
- Takes the raw 48-bit significand product, the unnormalized biased exponent and operand class bits.
- Produces the rounded 23-bit fraction, the 8-bit exponent, the denormal shift hint and one-hot exception flags, with a valid/ready handshake.

---
 rtl/fp_mul_norm_round.sv | 164 ++++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round.sv
`timescale 1ns/1ps
// fp_mul_norm_round: two-stage normalize / round-to-nearest-even stage of the FP32
// multiplier with valid/ready flow control and one-hot exception flags.
module fp_mul_norm_round #(
   parameter int EXP_W    = 10,
   parameter int UF_LIMIT = 22
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [47:0]             prod,
   input  logic signed [EXP_W-1:0] exp_sum,
   input  logic                    a_zero,
   input  logic                    b_zero,
   input  logic                    a_inf,
   input  logic                    b_inf,
   input  logic                    a_nan,
   input  logic                    b_nan,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [22:0]             M_out,
   output logic [7:0]              E_out,
   output logic [4:0]              required_shift,
   output logic                    overflow_flag,
   output logic                    underflow_flag,
   output logic                    invalid_flag,
   output logic                    zero_flag
);

   localparam logic signed [EXP_W-1:0] LP_ONE    = EXP_W'(1);
   localparam logic signed [EXP_W-1:0] LP_ZERO   = '0;
   localparam logic signed [EXP_W-1:0] LP_UF_MIN = EXP_W'(-UF_LIMIT);
   localparam logic signed [EXP_W-1:0] LP_E_MAX  = EXP_W'(255);

   logic                    w_s1_adv;
   logic                    w_s2_adv;

   logic                    r_s1_valid;
   logic [22:0]             r_s1_frac;
   logic                    r_s1_g;
   logic                    r_s1_s;
   logic signed [EXP_W-1:0] r_s1_e;
   logic [5:0]              r_s1_cls;

   logic [22:0]             w_n_frac;
   logic                    w_n_g;
   logic                    w_n_s;
   logic signed [EXP_W-1:0] w_n_e;

   logic                    w_up;
   logic [23:0]             w_sum;
   logic signed [EXP_W-1:0] w_e;
   logic                    w_any_zero;
   logic                    w_any_inf;
   logic                    w_any_nan;

   logic [22:0]             w_m_nxt;
   logic [7:0]              w_e8_nxt;
   logic [4:0]              w_rs_nxt;
   logic                    w_ov_nxt;
   logic                    w_uf_nxt;
   logic                    w_inv_nxt;
   logic                    w_zf_nxt;

   // Stage 2 is the output register, so out_valid doubles as s2_valid.
   assign w_s2_adv = ~out_valid | out_ready;
   assign w_s1_adv = ~r_s1_valid | w_s2_adv;
   assign in_ready = w_s1_adv;

   always_comb begin
      if (prod[47]) begin
         w_n_frac = prod[46:24];
         w_n_g    = prod[23];
         w_n_s    = |prod[22:0];
         w_n_e    = exp_sum + LP_ONE;
      end else begin
         w_n_frac = prod[45:23];
         w_n_g    = prod[22];
         w_n_s    = |prod[21:0];
         w_n_e    = exp_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_frac  <= '0;
         r_s1_g     <= 1'b0;
         r_s1_s     <= 1'b0;
         r_s1_e     <= '0;
         r_s1_cls   <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_frac <= w_n_frac;
            r_s1_g    <= w_n_g;
            r_s1_s    <= w_n_s;
            r_s1_e    <= w_n_e;
            r_s1_cls  <= {a_zero, b_zero, a_inf, b_inf, a_nan, b_nan};
         end
      end
   end

   // On a rounding carry the low 23 bits of the sum are already zero.
   assign w_up       = r_s1_g & (r_s1_s | r_s1_frac[0]);
   assign w_sum      = {1'b0, r_s1_frac} + {23'b0, w_up};
   assign w_e        = w_sum[23] ? (r_s1_e + LP_ONE) : r_s1_e;
   assign w_any_zero = r_s1_cls[5] | r_s1_cls[4];
   assign w_any_inf  = r_s1_cls[3] | r_s1_cls[2];
   assign w_any_nan  = r_s1_cls[1] | r_s1_cls[0];

   always_comb begin
      w_m_nxt   = w_sum[22:0];
      w_e8_nxt  = w_e[7:0];
      w_rs_nxt  = 5'd0;
      w_ov_nxt  = 1'b0;
      w_uf_nxt  = 1'b0;
      w_inv_nxt = 1'b0;
      w_zf_nxt  = 1'b0;
      if (w_any_nan | (w_any_inf & w_any_zero)) begin
         w_inv_nxt = 1'b1;
         w_m_nxt   = '0;
         w_e8_nxt  = '0;
      end else if (w_any_zero | (w_e < LP_UF_MIN)) begin
         w_zf_nxt  = 1'b1;
         w_m_nxt   = '0;
         w_e8_nxt  = '0;
      end else if (w_any_inf | (w_e >= LP_E_MAX)) begin
         w_ov_nxt  = 1'b1;
         w_m_nxt   = '0;
         w_e8_nxt  = 8'hFF;
      end else if (w_e <= LP_ZERO) begin
         // Downstream denormalizes by (1 - e) starting from this base shift.
         w_uf_nxt  = 1'b1;
         w_rs_nxt  = 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         M_out          <= '0;
         E_out          <= '0;
         required_shift <= '0;
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
         invalid_flag   <= 1'b0;
         zero_flag      <= 1'b0;
      end else if (w_s2_adv) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            M_out          <= w_m_nxt;
            E_out          <= w_e8_nxt;
            required_shift <= w_rs_nxt;
            overflow_flag  <= w_ov_nxt;
            underflow_flag <= w_uf_nxt;
            invalid_flag   <= w_inv_nxt;
            zero_flag      <= w_zf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
`timescale 1ns/1ps
// Scoreboard bench for fp_mul_norm_round: a real-valued rounding model predicts each
// accepted beat, and an independent monitor compares beats as they leave the DUT.
module tb_fp_mul_norm_round;

   localparam int EXP_W    = 10;
   localparam int UF_LIMIT = 22;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [47:0]             prod;
   logic signed [EXP_W-1:0] exp_sum;
   logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic                    out_valid;
   logic                    out_ready;
   logic [22:0]             M_out;
   logic [7:0]              E_out;
   logic [4:0]              required_shift;
   logic                    overflow_flag, underflow_flag, invalid_flag, zero_flag;

   int n_checks = 0;
   int n_pass   = 0;
   logic [39:0] sb_q[$];
   logic [39:0] w_out;
   logic [39:0] prev_out;
   bit          held = 1'b0;
   bit          stale_watch = 1'b0;
   int          stale_cnt = 0;
   bit          rand_done = 1'b0;

   fp_mul_norm_round #(.EXP_W(EXP_W), .UF_LIMIT(UF_LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .prod(prod), .exp_sum(exp_sum),
      .a_zero(a_zero), .b_zero(b_zero), .a_inf(a_inf), .b_inf(b_inf),
      .a_nan(a_nan), .b_nan(b_nan),
      .out_valid(out_valid), .out_ready(out_ready),
      .M_out(M_out), .E_out(E_out), .required_shift(required_shift),
      .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
      .invalid_flag(invalid_flag), .zero_flag(zero_flag)
   );

   always #5 clk = ~clk;

   assign w_out = {M_out, E_out, required_shift,
                   overflow_flag, underflow_flag, invalid_flag, zero_flag};

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Rounds the significand product as a number: keep 24 significant bits,
   // compare the discarded remainder against one half, break ties to even.
   function automatic logic [39:0] model(input logic [47:0] p, input int es, input logic [5:0] cls);
      longint unsigned pv, q, rem, half;
      int sh, e;
      logic [22:0] m;
      logic [7:0]  eo;
      logic [4:0]  rs;
      logic ov, uf, iv, zf;
      bit any_zero, any_inf, any_nan;
      any_zero = cls[5] | cls[4];
      any_inf  = cls[3] | cls[2];
      any_nan  = cls[1] | cls[0];
      pv   = 64'(p);
      sh   = p[47] ? 24 : 23;
      e    = p[47] ? es + 1 : es;
      q    = pv >> sh;
      half = 64'd1 << (sh - 1);
      rem  = pv - (q << sh);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e = e + 1;
      end
      m = q[22:0]; eo = 8'(e); rs = 5'd0;
      ov = 0; uf = 0; iv = 0; zf = 0;
      if (any_nan || (any_inf && any_zero)) begin iv = 1; m = 0; eo = 0; end
      else if (any_zero || e < -UF_LIMIT)   begin zf = 1; m = 0; eo = 0; end
      else if (any_inf || e >= 255)         begin ov = 1; m = 0; eo = 8'hFF; end
      else if (e <= 0)                      begin uf = 1; rs = 5'd1; end
      return {m, eo, rs, ov, uf, iv, zf};
   endfunction

   // Input side of the scoreboard: predict every beat the DUT accepts.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         sb_q.push_back(model(prod, int'(exp_sum), {a_zero, b_zero, a_inf, b_inf, a_nan, b_nan}));
   end

   // Output side: in-order compare, plus output stability while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held)
            chk(out_valid && w_out == prev_out, "hold_stable", {23'b0, out_valid, w_out}, {24'h1, prev_out});
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk(1'b0, "unexpected_beat", 64'(w_out), 64'(0));
            end else begin
               logic [39:0] exp_v;
               exp_v = sb_q.pop_front();
               chk(w_out == exp_v, "beat", 64'(w_out), 64'(exp_v));
            end
         end
         held = out_valid && !out_ready;
         prev_out = w_out;
         if (stale_watch && out_valid) stale_cnt++;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat has transferred.
   task automatic send(input logic [47:0] p, input int es, input logic [5:0] cls);
      int t;
      prod     = p;
      exp_sum  = EXP_W'(es);
      {a_zero, b_zero, a_inf, b_inf, a_nan, b_nan} = cls;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) chk(1'b0, "send_timeout", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] e1;
      logic [47:0] p;
      logic [23:0] ma, mb;
      logic [5:0]  cls;
      int es;

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; prod = '0; exp_sum = '0;
      {a_zero, b_zero, a_inf, b_inf, a_nan, b_nan} = 6'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(!out_valid && w_out == 40'b0, "reset_outputs", {23'b0, out_valid, w_out}, 64'(0));
      chk(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'(1));
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Directed vectors: 1.5x1.5, rounding carry, tie-to-even, exception classes.
      send(48'h9000_0000_0000, 127, 6'b0);
      send({2'b01, 23'h7FFFFF, 1'b1, 22'h0}, 100, 6'b0);
      send({2'b01, 23'h000002, 1'b1, 22'h0}, 100, 6'b0);
      send({2'b01, 23'h000003, 1'b1, 22'h0}, 100, 6'b0);
      send(48'h9000_0000_0000, 50, 6'b011000);
      send(48'h9000_0000_0000, 254, 6'b0);
      send({2'b01, 46'h0}, -2, 6'b0);
      send({2'b01, 46'h0}, -40, 6'b0);
      send({2'b01, 46'h0}, -22, 6'b0);
      send({2'b01, 46'h0}, -23, 6'b0);
      send({2'b01, 46'h0}, 0, 6'b000001);
      drain(6);

      // Backpressure: two beats fill the pipe, the third must wait.
      out_ready = 1'b0;
      send(48'h9000_0000_0000, 10, 6'b0);
      e1 = model(48'h9000_0000_0000, 10, 6'b0);
      send({2'b01, 23'h000003, 1'b1, 22'h0}, 20, 6'b0);
      fork
         send({2'b01, 23'h123456, 1'b0, 22'h1}, 30, 6'b0);
         begin
            repeat (3) begin
               @(negedge clk);
               chk(!in_ready, "bp_in_ready_low", 64'(in_ready), 64'(0));
               chk(out_valid && w_out == e1, "bp_holds_beat1", {23'b0, out_valid, w_out}, {24'h1, e1});
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk(out_valid, "bp_drain_consecutive", 64'(out_valid), 64'(1));
            end
         end
      join
      drain(6);

      // Asynchronous reset with two beats buffered.
      out_ready = 1'b0;
      send(48'h9000_0000_0000, 60, 6'b0);
      send(48'hA000_0000_0000, 61, 6'b0);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk(!out_valid && w_out == 40'b0, "async_reset_outputs", {23'b0, out_valid, w_out}, 64'(0));
      sb_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale_watch = 1'b1;
      repeat (6) @(negedge clk);
      stale_watch = 1'b0;
      chk(stale_cnt == 0, "no_stale_beat", 64'(stale_cnt), 64'(0));
      @(posedge clk); #1;

      // Randomized traffic with random downstream stalls.
      fork
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
         end
         begin
            for (int i = 0; i < 400; i++) begin
               ma  = {1'b1, 23'($urandom)};
               mb  = {1'b1, 23'($urandom)};
               p   = {24'b0, ma} * {24'b0, mb};
               es  = int'($urandom_range(0, 440)) - 127;
               for (int k = 0; k < 6; k++) cls[k] = ($urandom_range(0, 15) == 0);
               send(p, es, cls);
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            rand_done = 1'b1;
         end
      join
      drain(10);
      @(negedge clk);
      chk(sb_q.size() == 0, "scoreboard_empty", 64'(sb_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
